larng_uart_tx: RTL
==================

# larng_uart_tx

UART transmitter for the laRNG user project. It accepts random bytes from the RNG core through a valid/ready handshake and buffers them in a small FIFO. It serializes each byte as 8N1 frames on the user GPIO that feeds the bench UART monitor (mprj_io[6]). It is the transmitting end of the serial link that the testbench UART receiver decodes.

## Interface
Parameters:
- CLK_DIV, 4167: clock cycles per UART bit (40 MHz / 9600 baud). Legal range ≥ 2.
- FIFO_DEPTH, 4: byte entries. Must be a power of two, ≥ 2.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- resetb  in  1  asynchronous active-low reset.
- din  in  8  byte to transmit.
- din_valid  in  1  producer offers din.
- din_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  serial line, idle high.
- busy  out  1  high while a frame is in flight or the FIFO is non-empty.
- overflow  out  1  sticky flag; set when din_valid is high while din_ready is low. Cleared only by reset.

## Operation
- Push: a byte is written into the FIFO on a clock edge where din_valid && din_ready.
- din_ready is registered-state derived (!full). It does not look ahead at a same-cycle pop.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA.
  - DATA: tx=shift[0], sent LSB first. Each bit lasts CLK_DIV cycles; 8 bits using bit index 0..7. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: tx=^byte (even parity) for CLK_DIV cycles, then go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then pop and go to START if the FIFO is non-empty (back-to-back frames, no idle gap); otherwise go to IDLE.
- Baud counter: width $clog2(CLK_DIV). It counts 0..CLK_DIV-1, restarts at 0 on every state change, and wraps without overflow.
- FIFO boundaries:
  - A push when full is dropped and overflow is set.
  - A pop never occurs when empty.
  - A push on the same edge as a pop while not full is accepted; occupancy is unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit for full/empty.
- din is sampled only on accepted edges. Changes to din while not accepted are ignored.

## Timing
- Reset values: tx=1, din_ready=1, busy=0, overflow=0, FSM=IDLE, FIFO empty, counters 0.
- resetb assertion mid-frame forces tx=1 immediately (asynchronous), aborts the frame and discards FIFO contents.
- Latency from an idle FIFO: byte accepted at edge N → FSM pops at edge N+1 → tx falls after edge N+1.
- Frame length: 10×CLK_DIV cycles, or 11×CLK_DIV with parity.
- busy rises the cycle after the first accepted push. It falls on the edge where STOP completes with the FIFO empty.
- tx is driven directly from a flop, so there are no glitches.

## Configuration
- LARNG_UART_TX_PARITY_EN
  - Defined: the PARITY state is present and an even-parity bit is inserted between data bit 7 and stop.
  - Undefined: the PARITY state and its logic are absent; frames are 8N1.

## Structure
- Package larng_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - UART_DATA_BITS=8;
  - default CLK_DIV constant.
- Sub-module larng_uart_tx_fifo: synchronous byte FIFO (push/pop/full/empty). The top-level larng_uart_tx holds the FSM, baud counter, shift register and overflow flag.

## Test plan
Bench setting: CLK_DIV=4, FIFO_DEPTH=4, parity off unless stated.
- Single byte 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. Total 40 cycles, then busy=0.
- Push 0x00, 0xFF back-to-back → the second start bit begins on the cycle immediately after the first stop bit ends; no idle cycle between frames.
- Hold din_valid for 6 bytes while idle:
  - 4 bytes are accepted (1 is popped at once, so 5 accepted in total);
  - din_ready drops;
  - the 6th byte is dropped and overflow=1;
  - the 5 accepted bytes are transmitted in order.
- Assert resetb low at cycle 15 of a frame → tx=1 the same cycle, busy=0, and the FIFO is empty after release; a new byte 0x3C then transmits correctly.
- With LARNG_UART_TX_PARITY_EN: byte 0x07 → parity bit 1, frame 44 cycles; byte 0x03 → parity bit 0.
- Data integrity: push 0x01, 0x80, 0x55 and sample tx mid-bit → the decoded bytes match exactly and no framing error occurs (every stop bit is 1).

Source files
------------

// File: rtl/larng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : larng_pkg
// Description : Shared types and constants for the laRNG UART transmitter.
//               Holds the transmitter state encoding, the UART data width,
//               the default bit period and an even-parity helper.
// Optional    : LARNG_UART_TX_PARITY_EN (consumed by larng_uart_tx)
// Revision    : 1.0 - initial release
// ============================================================================
package larng_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_BIT_IDX_W  = $clog2(UART_DATA_BITS);
    // 40 MHz system clock / 9600 baud
    localparam int unsigned DEFAULT_CLK_DIV = 4167;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/larng_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : larng_uart_tx_fifo
// Description : Synchronous byte FIFO buffering RNG bytes ahead of the UART
//               serializer. Pointers carry one extra wrap bit so that full
//               and empty are distinguished without a separate counter.
//               Pushes while full and pops while empty are ignored.
// Ports       : clock, resetb   - clock / async active-low reset
//               push_i, wdata_i - write strobe and byte
//               pop_i, rdata_o  - read strobe and head-of-queue byte
//               full_o, empty_o - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module larng_uart_tx_fifo
    import larng_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      resetb,
    input  logic                      push_i,
    input  logic [UART_DATA_BITS-1:0] wdata_i,
    input  logic                      pop_i,
    output logic [UART_DATA_BITS-1:0] rdata_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]               wptr_q;
    logic [AW:0]               rptr_q;
    logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                      push_ok;
    logic                      pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    // Same slot index, opposite lap: the writer is a full lap ahead.
    assign full_o  = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/larng_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : larng_uart_tx
// Description : UART transmitter for laRNG. Accepts bytes over a
//               valid/ready handshake into a small FIFO and serializes them
//               LSB first as 8N1 frames (8E1 when parity is enabled).
//               Frames are sent back-to-back while the FIFO holds data.
// Ports       : clock, resetb - clock / async active-low reset
//               din, din_valid, din_ready - byte producer handshake
//               tx       - serial line, idle high, driven from a flop
//               busy     - frame in flight or FIFO non-empty
//               overflow - sticky, a byte was offered while not ready
// Optional    : LARNG_UART_TX_PARITY_EN inserts an even-parity bit between
//               data bit 7 and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module larng_uart_tx
    import larng_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      resetb,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic                      tx,
    output logic                      busy,
    output logic                      overflow
);

    localparam int unsigned      CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          baud_q, baud_d;
    logic [UART_BIT_IDX_W-1:0] bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      overflow_q;
`ifdef LARNG_UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    logic                      fifo_pop;
    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      baud_end;

    larng_uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetb  (resetb),
        .push_i  (din_valid),
        .wdata_i (din),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign din_ready = !fifo_full;
    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow  = overflow_q;
    assign baud_end  = (baud_q == BAUD_LAST);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef LARNG_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            if (din_valid && !din_ready) overflow_q <= 1'b1;
`ifdef LARNG_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // tx_d is the line level of the state being entered, so the registered
    // tx lines up exactly with state_q and never glitches.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
`ifdef LARNG_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
`ifdef LARNG_UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_rdata);
`endif
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef LARNG_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef LARNG_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = ST_START;
                        tx_d     = 1'b0;
`ifdef LARNG_UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_rdata);
`endif
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire
